or1200_pad_gen: RTL and testbench

- Iterative keystream (pad) generator that sits directly downstream of the encryption control FSM.
- Consumes `enc_start`, `enc_key` and `enc_seed`; runs a fixed number of ARX rounds, one per clock.
- Returns a 128-bit `enc_pad` and a single-cycle `enc_done` pulse. The FSM latches the pad and XORs it onto load/store data.

---
 rtl/or1200_pad_gen.sv | 84 ++++++++
 tb/tb_or1200_pad_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_pad_gen.sv
// Iterative ARX keystream generator: one round per clock, 128-bit pad plus a done pulse
// for the encryption control FSM.
module or1200_pad_gen #(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned ROT    = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc_start,
  input  logic [127:0] enc_key,
  input  logic [127:0] enc_seed,
  output logic [127:0] enc_pad,
  output logic         enc_done,
  output logic         busy
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [7:0] LastRound = 8'(ROUNDS - 1);

  state_e            state_q;
  logic [7:0]        r_q;
  logic [3:0][31:0]  s_q;
  logic [3:0][31:0]  k_q;
  logic [127:0]      pad_q;
  logic              done_q;
  logic              busy_q;

  logic [31:0]       round_t;
  logic [31:0]       round_n;
  logic [3:0][31:0]  s_d;

  function automatic logic [31:0] rotl(input logic [31:0] x);
    return (x << ROT) | (x >> (32 - ROT));
  endfunction

  // One ARX round on the current state; s_d is the post-round state.
  always_comb begin
    round_t = s_q[0] + k_q[r_q[1:0]] + {24'b0, r_q};
    round_n = rotl(round_t) ^ s_q[3];
    s_d     = {round_n, s_q[3], s_q[2], s_q[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      pad_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enc_start) begin
            s_q     <= enc_seed;
            k_q     <= enc_key;
            r_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          s_q <= s_d;
          r_q <= r_q + 8'd1;
          if (r_q == LastRound) begin
            pad_q   <= s_d ^ k_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign enc_pad  = pad_q;
  assign enc_done = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_or1200_pad_gen.sv
// Directed bench for or1200_pad_gen: a ROUNDS=1 and a ROUNDS=16 instance, each with an
// expected-pad queue filled at start and drained on enc_done.
module tb_or1200_pad_gen;

  localparam int unsigned Rot = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start1 = 1'b0, start16 = 1'b0;
  logic [127:0] key1 = '0, seed1 = '0, key16 = '0, seed16 = '0;
  logic [127:0] pad1, pad16;
  logic         done1, done16, busy1, busy16;

  int checks = 0;
  int errors = 0;

  logic [127:0] sb1[$];
  logic [127:0] sb16[$];

  int cyc, busy_cnt, done_cnt, done_idx, done1_cnt;
  logic [127:0] exp_a, exp_b, exp_c;

  always #5 clk = ~clk;

  or1200_pad_gen #(.ROUNDS(1), .ROT(Rot)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .enc_start(start1),
    .enc_key  (key1),
    .enc_seed (seed1),
    .enc_pad  (pad1),
    .enc_done (done1),
    .busy     (busy1)
  );

  or1200_pad_gen #(.ROUNDS(16), .ROT(Rot)) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .enc_start(start16),
    .enc_key  (key16),
    .enc_seed (seed16),
    .enc_pad  (pad16),
    .enc_done (done16),
    .busy     (busy16)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pad_ref(input logic [127:0] key, input logic [127:0] seed,
                                           input int rounds);
    logic [31:0] s[4];
    logic [31:0] k[4];
    logic [31:0] t, n;
    for (int i = 0; i < 4; i++) begin
      s[i] = seed[32*i +: 32];
      k[i] = key[32*i +: 32];
    end
    for (int r = 0; r < rounds; r++) begin
      t = s[0] + k[r % 4] + 32'(r);
      n = ((t << Rot) | (t >> (32 - Rot))) ^ s[3];
      s[0] = s[1];
      s[1] = s[2];
      s[2] = s[3];
      s[3] = n;
    end
    return {s[3], s[2], s[1], s[0]} ^ key;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock, sample 1 time unit later and drain the scoreboards on done.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy16) busy_cnt++;
    if (done16) begin
      done_cnt++;
      done_idx = cyc;
      if (sb16.size() == 0) check("sb16_unexpected_done", 128'd1, 128'd0);
      else check("pad16", pad16, sb16.pop_front());
    end
    if (done1) begin
      done1_cnt++;
      if (sb1.size() == 0) check("sb1_unexpected_done", 128'd1, 128'd0);
      else check("pad1", pad1, sb1.pop_front());
    end
    cyc++;
  endtask

  task automatic clear_counts();
    cyc = 0;
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_counts();
    done1_cnt = 0;

    // Reset held with start asserted: nothing may begin.
    start1 = 1'b1;
    start16 = 1'b1;
    tick();
    tick();
    check("rst_pad16", pad16, 128'd0);
    check("rst_done16", 128'(done16), 128'd0);
    check("rst_busy16", 128'(busy16), 128'd0);
    check("rst_pad1", pad1, 128'd0);
    check("rst_busy1", 128'(busy1), 128'd0);
    start1 = 1'b0;
    start16 = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_busy16", 128'(busy16), 128'd0);
    check("post_rst_busy1", 128'(busy1), 128'd0);

    // ROUNDS=1, key=0, seed=1.
    key1 = '0;
    seed1 = 128'h1;
    start1 = 1'b1;
    sb1.push_back(128'h00000080_00000000_00000000_00000000);
    tick();
    start1 = 1'b0;
    check("r1a_busy", 128'(busy1), 128'd1);
    check("r1a_done_early", 128'(done1), 128'd0);
    tick();
    check("r1a_done", 128'(done1), 128'd1);
    check("r1a_busy_end", 128'(busy1), 128'd0);
    tick();
    check("r1a_done_pulse", 128'(done1), 128'd0);
    check("r1a_pad_hold", pad1, 128'h00000080_00000000_00000000_00000000);

    // ROUNDS=1, key=1, seed=0.
    key1 = 128'h1;
    seed1 = '0;
    start1 = 1'b1;
    sb1.push_back(128'h00000080_00000000_00000000_00000001);
    tick();
    start1 = 1'b0;
    tick();
    check("r1b_done", 128'(done1), 128'd1);
    tick();
    check("r1_done_count", 128'(done1_cnt), 128'd2);

    // ROUNDS=16, random operands, inputs scrambled mid-run.
    key16 = rnd128();
    seed16 = rnd128();
    exp_a = pad_ref(key16, seed16, 16);
    sb16.push_back(exp_a);
    start16 = 1'b1;
    clear_counts();
    tick();
    start16 = 1'b0;
    key16 = rnd128();
    seed16 = rnd128();
    repeat (20) tick();
    check("r16_busy_cycles", 128'(busy_cnt), 128'd16);
    check("r16_done_count", 128'(done_cnt), 128'd1);
    check("r16_done_cycle", 128'(done_idx), 128'd16);
    check("r16_pad_hold", pad16, exp_a);

    // Mid-run start ignored, then back-to-back start in the done cycle.
    key16 = rnd128();
    seed16 = rnd128();
    exp_b = pad_ref(key16, seed16, 16);
    sb16.push_back(exp_b);
    start16 = 1'b1;
    clear_counts();
    tick();
    start16 = 1'b0;
    repeat (4) tick();
    key16 = rnd128();
    seed16 = rnd128();
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    check("mid_old_pad", pad16, exp_a);
    for (int i = 0; i < 40 && !done16; i++) tick();
    check("b2b_first_done_cycle", 128'(done_idx), 128'd16);
    key16 = rnd128();
    seed16 = rnd128();
    exp_c = pad_ref(key16, seed16, 16);
    sb16.push_back(exp_c);
    start16 = 1'b1;
    clear_counts();
    tick();
    start16 = 1'b0;
    check("b2b_busy", 128'(busy16), 128'd1);
    repeat (8) tick();
    check("b2b_old_pad", pad16, exp_b);
    repeat (12) tick();
    check("b2b_done_count", 128'(done_cnt), 128'd1);
    check("b2b_done_cycle", 128'(done_idx), 128'd16);
    check("b2b_pad_final", pad16, exp_c);

    // Abort at round 5: no done, pad cleared.
    key16 = rnd128();
    seed16 = rnd128();
    start16 = 1'b1;
    clear_counts();
    tick();
    start16 = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("abort_busy", 128'(busy16), 128'd0);
    check("abort_pad", pad16, 128'd0);
    check("abort_done", 128'(done16), 128'd0);
    rst = 1'b1;
    repeat (30) tick();
    check("abort_no_done", 128'(done_cnt), 128'd0);
    check("abort_busy_idle", 128'(busy16), 128'd0);
    check("sb16_drained", 128'(sb16.size()), 128'd0);
    check("sb1_drained", 128'(sb1.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
